modbus_rtu_responder: RTL and testbench

Modbus RTU slave (responder) for the far end of the host-driven UART Modbus link. It consumes received bytes from a uart_rx-style byte interface and delimits frames by line silence. It validates address and CRC16, then executes FC03 (read holding registers) or FC06 (write single register) against an internal register bank. It streams the response through a uart_tx-style byte interface and drives the RS485 driver enable.

---
 rtl/modbus_rtu_responder.sv | 173 +++++++++++++++++
 tb/tb_modbus_rtu_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/modbus_rtu_responder.sv
// Modbus RTU responder: silence-delimited frame receive, CRC16 check, FC03/FC06 execution against a register bank.
// Build option MODBUS_INPUT_REGS_EN adds the regs_in port and FC04 (read input registers).
module modbus_rtu_responder #(
  parameter int ClkFrequency = 12000000,
  parameter int Baud         = 9600,
  parameter int SLAVE_ADDR   = 1,
  parameter int NUM_REGS     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic                    tx_enable,
  output logic [NUM_REGS*16-1:0]  regs_out,
`ifdef MODBUS_INPUT_REGS_EN
  input  logic [NUM_REGS*16-1:0]  regs_in,
`endif
  output logic                    reg_wr,
  output logic [7:0]              reg_wr_addr,
  output logic                    frame_ok,
  output logic                    crc_error
);
  localparam int BIT_CYC = ClkFrequency / Baud;
  localparam int T35     = 39 * BIT_CYC;
  localparam int SW      = $clog2(T35 + 1);
  localparam logic [SW-1:0] T35_C = SW'(T35);

  typedef enum logic [2:0] {IDLE, RECV, CHECK, EXEC, SEND, DRAIN} state_t;
  typedef enum logic [1:0] {K_READ, K_ECHO, K_EXC} kind_t;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  state_t         state, state_n;
  kind_t          kind;
  logic [7:0]     fbuf [8];
  logic [3:0]     rxlen;
  logic           ovf;
  logic [15:0]    rx_crc, tx_crc;
  logic [SW-1:0]  sil;
  logic [7:0]     rsp_len, tx_idx, exc_code, exc, tx_byte, rd_off, ridx;
  logic [15:0]    start, qty, rword;
  logic           is_rd, accept, hdr_ok, crc_ok, issue, last, seen_busy;
`ifdef MODBUS_INPUT_REGS_EN
  logic           rd_in, src_in;
`endif

  assign start     = {fbuf[2], fbuf[3]};
  assign qty       = {fbuf[4], fbuf[5]};
  assign tx_enable = (state == SEND) || (state == DRAIN);
  assign accept    = rx_valid && (state == IDLE || state == RECV);
  assign hdr_ok    = (rxlen == 4'd8) && !ovf && (fbuf[0] == 8'(SLAVE_ADDR) || fbuf[0] == 8'h00);
  assign crc_ok    = rx_crc == {fbuf[7], fbuf[6]};
  assign issue     = (state == SEND) && !tx_busy && !tx_start;
  assign last      = tx_idx == rsp_len + 8'd1;

  // Request decode; exc==0 means the request is executable.
  always_comb begin
    is_rd = fbuf[1] == 8'h03;
`ifdef MODBUS_INPUT_REGS_EN
    rd_in = fbuf[1] == 8'h04;
    is_rd = is_rd || rd_in;
`endif
    exc = 8'h00;
    if (is_rd) begin
      if (qty == 16'd0 || qty > 16'd125) exc = 8'h03;
      else if ({1'b0, start} + {1'b0, qty} > 17'(NUM_REGS)) exc = 8'h02;
    end else if (fbuf[1] == 8'h06) begin
      if (start >= 16'(NUM_REGS)) exc = 8'h02;
    end else exc = 8'h01;
  end

  // Response byte for the current tx_idx; CRC bytes follow the body.
  always_comb begin
    rd_off = tx_idx - 8'd3;
    ridx   = start[7:0] + {1'b0, rd_off[7:1]};
    rword  = 16'h0000;
    if (ridx < 8'(NUM_REGS)) begin
`ifdef MODBUS_INPUT_REGS_EN
      rword = src_in ? regs_in[int'(ridx)*16 +: 16] : regs_out[int'(ridx)*16 +: 16];
`else
      rword = regs_out[int'(ridx)*16 +: 16];
`endif
    end
    tx_byte = 8'h00;
    case (kind)
      K_EXC:   tx_byte = (tx_idx == 8'd0) ? fbuf[0] : (tx_idx == 8'd1) ? (fbuf[1] | 8'h80) : exc_code;
      K_ECHO:  tx_byte = fbuf[tx_idx[2:0]];
      default: tx_byte = (tx_idx == 8'd0) ? fbuf[0] : (tx_idx == 8'd1) ? fbuf[1] :
                         (tx_idx == 8'd2) ? (rsp_len - 8'd3) : (rd_off[0] ? rword[7:0] : rword[15:8]);
    endcase
    if (tx_idx == rsp_len) tx_byte = tx_crc[7:0];
    else if (last) tx_byte = tx_crc[15:8];
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = RECV;
      RECV:    if (!accept && sil == T35_C && rxlen != 4'd0) state_n = CHECK;
      CHECK:   state_n = (hdr_ok && crc_ok) ? EXEC : IDLE;
      EXEC:    state_n = (fbuf[0] == 8'h00) ? IDLE : SEND;
      SEND:    if (issue && last) state_n = DRAIN;
      DRAIN:   if (seen_busy && !tx_busy) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) fbuf[i] <= 8'h00;
      rxlen <= '0; ovf <= 1'b0; rx_crc <= 16'hFFFF; sil <= '0;
      tx_crc <= 16'hFFFF; tx_idx <= '0; rsp_len <= '0; exc_code <= '0; kind <= K_READ;
      seen_busy <= 1'b0; tx_data <= '0; tx_start <= 1'b0; regs_out <= '0;
      reg_wr <= 1'b0; reg_wr_addr <= '0; frame_ok <= 1'b0; crc_error <= 1'b0;
`ifdef MODBUS_INPUT_REGS_EN
      src_in <= 1'b0;
`endif
    end else begin
      frame_ok <= 1'b0; crc_error <= 1'b0; reg_wr <= 1'b0; tx_start <= 1'b0;
      if (accept) sil <= '0;
      else if (sil != T35_C) sil <= sil + 1'b1;
      if (accept) begin
        if (rxlen < 4'd8) begin
          fbuf[rxlen[2:0]] <= rx_data;
          rxlen <= rxlen + 4'd1;
          if (rxlen < 4'd6) rx_crc <= crc_step(rx_crc, rx_data);
        end else ovf <= 1'b1;
      end
      if (state == CHECK) begin
        rxlen <= '0; ovf <= 1'b0; rx_crc <= 16'hFFFF;
        if (hdr_ok) begin
          frame_ok  <= crc_ok;
          crc_error <= !crc_ok;
        end
      end
      if (state == EXEC) begin
        tx_idx <= '0; tx_crc <= 16'hFFFF; seen_busy <= 1'b0; exc_code <= exc;
`ifdef MODBUS_INPUT_REGS_EN
        src_in <= rd_in;
`endif
        if (exc != 8'h00) begin
          kind <= K_EXC; rsp_len <= 8'd3;
        end else if (is_rd) begin
          kind <= K_READ; rsp_len <= 8'd3 + {qty[6:0], 1'b0};
        end else begin
          // Write lands before the echo goes out, broadcast or not.
          kind <= K_ECHO; rsp_len <= 8'd6;
          regs_out[int'(start[7:0])*16 +: 16] <= qty;
          reg_wr <= 1'b1; reg_wr_addr <= start[7:0];
        end
      end
      if (issue) begin
        tx_data  <= tx_byte;
        tx_start <= 1'b1;
        tx_idx   <= tx_idx + 8'd1;
        if (tx_idx < rsp_len) tx_crc <= crc_step(tx_crc, tx_byte);
      end
      if (state == DRAIN && tx_busy) seen_busy <= 1'b1;
    end
  end
endmodule

// File: tb/tb_modbus_rtu_responder.sv
// Directed bench for modbus_rtu_responder with a simple busy-timed UART transmitter model.
module tb_modbus_rtu_responder;
  localparam int NR = 8;
  typedef logic [7:0] bq_t[$];

  logic clk = 0, rst = 1, rx_valid = 0, tx_busy = 0;
  logic [7:0] rx_data = 0, tx_data, reg_wr_addr;
  logic tx_start, tx_enable, reg_wr, frame_ok, crc_error;
  logic [NR*16-1:0] regs_out;
`ifdef MODBUS_INPUT_REGS_EN
  logic [NR*16-1:0] regs_in = {{(NR-1){16'h0000}}, 16'hBEEF};
`endif

  int total = 0, bad = 0;
  int n_ok = 0, n_crc = 0, n_wr = 0, n_en = 0, n_noen = 0, n_fb = 0, bcnt = 0;
  logic en_q = 0;
  logic [7:0] txq[$];

  modbus_rtu_responder #(.ClkFrequency(1000000), .Baud(100000), .SLAVE_ADDR(1), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .tx_enable(tx_enable),
    .regs_out(regs_out),
`ifdef MODBUS_INPUT_REGS_EN
    .regs_in(regs_in),
`endif
    .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr), .frame_ok(frame_ok), .crc_error(crc_error));

  always #5 clk = ~clk;

  // Transmitter model: busy for 20 cycles per byte.
  always @(posedge clk) begin
    if (tx_start) begin
      txq.push_back(tx_data);
      tx_busy <= 1'b1;
      bcnt <= 20;
    end else if (bcnt > 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) tx_busy <= 1'b0;
    end
  end

  always @(posedge clk) begin
    en_q <= tx_enable;
    if (frame_ok) n_ok <= n_ok + 1;
    if (crc_error) n_crc <= n_crc + 1;
    if (reg_wr) n_wr <= n_wr + 1;
    if (tx_enable) n_en <= n_en + 1;
    if (tx_start && !tx_enable) n_noen <= n_noen + 1;
    if (en_q && !tx_enable && tx_busy && !rst) n_fb <= n_fb + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc16(input bq_t q);
    logic [15:0] c = 16'hFFFF;
    foreach (q[i]) begin
      c ^= {8'h00, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  function automatic bq_t with_crc(input bq_t q);
    bq_t r = q;
    logic [15:0] c = crc16(q);
    r.push_back(c[7:0]);
    r.push_back(c[15:8]);
    return r;
  endfunction

  task automatic send(input bq_t f, input int wait_cyc);
    foreach (f[i]) begin
      @(posedge clk); #1;
      rx_data = f[i]; rx_valid = 1;
      @(posedge clk); #1;
      rx_valid = 0;
      repeat (12) @(posedge clk);
    end
    repeat (wait_cyc) @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input int base, input bq_t e);
    chk({tag, "_len"}, txq.size() - base, e.size());
    foreach (e[i]) if (base + i < txq.size()) chk(tag, {24'h0, txq[base + i]}, {24'h0, e[i]});
    chk({tag, "_en_off"}, {31'h0, tx_enable}, 0);
  endtask

  int b, ok0, crc0, wr0, en0;
  bq_t f;

  task automatic snap();
    b = txq.size(); ok0 = n_ok; crc0 = n_crc; wr0 = n_wr; en0 = n_en;
  endtask

  initial begin
    repeat (3) @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("rst_tx_enable", {31'h0, tx_enable}, 0);
    chk("rst_tx_start", {31'h0, tx_start}, 0);
    chk("rst_tx_data", {24'h0, tx_data}, 0);
    chk("rst_reg0", {16'h0, regs_out[15:0]}, 0);
    chk("rst_pulses", {29'h0, frame_ok, crc_error, reg_wr}, 0);
    chk("rst_wr_addr", {24'h0, reg_wr_addr}, 0);

    snap(); send('{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A}, 1200);
    chk_rsp("rd1", b, '{8'h01, 8'h03, 8'h02, 8'h00, 8'h00, 8'hB8, 8'h44});
    chk("rd1_frame_ok", n_ok - ok0, 1);
    chk("rd1_en_after_busy", n_fb, 0);

    snap(); send('{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B}, 1200);
    chk_rsp("wr1", b, '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B});
    chk("wr1_reg1", {16'h0, regs_out[31:16]}, 32'h0003);
    chk("wr1_reg_wr", n_wr - wr0, 1);
    chk("wr1_wr_addr", {24'h0, reg_wr_addr}, 1);

    snap(); send(with_crc('{8'h01, 8'h03, 8'h00, 8'h08, 8'h00, 8'h01}), 1200);
    chk_rsp("exc02", b, '{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1});

    snap(); send('{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0B}, 1200);
    chk("badcrc_crc_error", n_crc - crc0, 1);
    chk("badcrc_frame_ok", n_ok - ok0, 0);
    chk("badcrc_no_tx", txq.size() - b, 0);
    chk("badcrc_no_en", n_en - en0, 0);

    snap(); send(with_crc('{8'h00, 8'h06, 8'h00, 8'h02, 8'h12, 8'h34}), 1200);
    chk("bcast_reg2", {16'h0, regs_out[47:32]}, 32'h1234);
    chk("bcast_reg_wr", n_wr - wr0, 1);
    chk("bcast_no_tx", txq.size() - b, 0);
    chk("bcast_no_en", n_en - en0, 0);

    snap(); send(with_crc('{8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01}), 1200);
    chk("addr2_pulses", (n_ok - ok0) + (n_crc - crc0) + (n_wr - wr0), 0);
    chk("addr2_no_tx", txq.size() - b, 0);

    snap(); send(with_crc('{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h03}), 1200);
    chk_rsp("rd3", b, with_crc('{8'h01, 8'h03, 8'h06, 8'h00, 8'h00, 8'h00, 8'h03, 8'h12, 8'h34}));

    snap(); send(with_crc('{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00}), 1200);
    chk_rsp("qty0", b, with_crc('{8'h01, 8'h83, 8'h03}));

    snap(); send(with_crc('{8'h01, 8'h06, 8'h00, 8'h08, 8'h00, 8'h01}), 1200);
    chk_rsp("wr_oob", b, with_crc('{8'h01, 8'h86, 8'h02}));
    chk("wr_oob_reg_wr", n_wr - wr0, 0);

    snap(); send(with_crc('{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01}), 1200);
    chk_rsp("fc10", b, with_crc('{8'h01, 8'h90, 8'h01}));

    snap(); send(with_crc('{8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h01}), 1200);
`ifdef MODBUS_INPUT_REGS_EN
    chk_rsp("fc04", b, with_crc('{8'h01, 8'h04, 8'h02, 8'hBE, 8'hEF}));
`else
    chk_rsp("fc04", b, with_crc('{8'h01, 8'h84, 8'h01}));
`endif

    // Nine bytes: overflow discards the frame.
    f = with_crc('{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01});
    f.push_back(8'h55);
    snap(); send(f, 1200);
    chk("ovf_no_tx", txq.size() - b, 0);
    chk("ovf_pulses", (n_ok - ok0) + (n_crc - crc0), 0);

    snap(); send('{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84}, 1200);
    chk("short_no_tx", txq.size() - b, 0);
    chk("short_pulses", (n_ok - ok0) + (n_crc - crc0), 0);

    // Reset while the third response byte is on the wire.
    snap(); send(with_crc('{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h08}), 0);
    for (int i = 0; i < 3000 && txq.size() < b + 3; i++) begin
      @(posedge clk); #1;
    end
    chk("rst_mid_reached", {31'h0, txq.size() >= b + 3}, 1);
    rst = 1; #1;
    chk("rst_mid_tx_enable", {31'h0, tx_enable}, 0);
    chk("rst_mid_tx_start", {31'h0, tx_start}, 0);
    chk("rst_mid_reg1", {16'h0, regs_out[31:16]}, 0);
    chk("rst_mid_reg2", {16'h0, regs_out[47:32]}, 0);
    repeat (30) @(posedge clk); #1;
    rst = 0;
    repeat (5) @(posedge clk); #1;
    snap(); send(with_crc('{8'h01, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02}), 1200);
    chk_rsp("after_rst", b, with_crc('{8'h01, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00}));
    chk("after_rst_frame_ok", n_ok - ok0, 1);

    chk("start_without_enable", n_noen, 0);
    chk("enable_fell_while_busy", n_fb, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
